// File: rtl/ram_cmd_ctrl_if.sv
// Command/response handshake bundle between an upstream requester and ram_cmd_ctrl.
// master = requester side, slave = controller side.
interface ram_cmd_ctrl_if #(
  parameter int unsigned MEM_WIDTH = 16,
  parameter int unsigned ADDR_SIZE = 10
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_op;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [MEM_WIDTH-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [MEM_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ram_cmd_ctrl.sv
// Command sequencer for the single-port parity RAM: drives RAM pins per state and returns read data.
// Optional feature macro: PARITY_CHECK_EN (parity check of ram_dout, rsp_err and err_cnt).
module ram_cmd_ctrl #(
  parameter int unsigned MEM_WIDTH  = 16,
  parameter int unsigned ADDR_SIZE  = 10,
  parameter int unsigned ADDR_PIPE  = 0,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_cmd_ctrl_if.slave        bus,
  output logic [7:0]           err_cnt,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_blk_sel,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic blk_sel;
    logic addr_en;
    logic wr_en;
    logic rd_en;
    logic dout_en;
    logic cmd_ready;
    logic rsp_valid;
  } ctl_t;

  state_t               state;
  ctl_t                 ctl;
  logic                 op_q;
  logic [CNT_W-1:0]     cnt;
  logic [MEM_WIDTH-1:0] rsp_data_q;
  logic                 rsp_err_q;
  logic                 par_err_c;

  // Control pin values for a given state; registered together with the state so they track it exactly.
  function automatic ctl_t decode(input state_t s, input logic op);
    ctl_t c;
    c = '0;
    case (s)
      S_IDLE:  c.cmd_ready = 1'b1;
      S_SETUP: c.addr_en   = 1'b1;
      S_ISSUE: begin
        c.blk_sel = 1'b1;
        c.addr_en = 1'b1;
        c.wr_en   = ~op;
        c.rd_en   = op;
      end
      S_WAIT: begin
        c.blk_sel = 1'b1;
        c.dout_en = 1'b1;
      end
      S_RESP:  c.rsp_valid = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef PARITY_CHECK_EN
  assign par_err_c = (ram_parity != ~^ram_dout);
`else
  logic unused_parity;
  assign unused_parity = ram_parity;
  assign par_err_c     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ctl        <= '0;
      op_q       <= 1'b0;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && ctl.cmd_ready) begin
            ram_addr <= bus.cmd_addr;
            ram_din  <= bus.cmd_data;
            op_q     <= bus.cmd_op;
            if (ADDR_PIPE != 0) begin
              state <= S_SETUP;
              ctl   <= decode(S_SETUP, bus.cmd_op);
            end else begin
              state <= S_ISSUE;
              ctl   <= decode(S_ISSUE, bus.cmd_op);
            end
          end else begin
            ctl <= decode(S_IDLE, 1'b0);
          end
        end
        S_SETUP: begin
          state <= S_ISSUE;
          ctl   <= decode(S_ISSUE, op_q);
        end
        S_ISSUE: begin
          if (op_q) begin
            state <= S_WAIT;
            cnt   <= CNT_W'(RD_LATENCY - 1);
            ctl   <= decode(S_WAIT, op_q);
          end else begin
            state <= S_IDLE;
            ctl   <= decode(S_IDLE, 1'b0);
          end
        end
        S_WAIT: begin
          // Last WAIT edge: RAM output is valid now
          if (cnt == '0) begin
            rsp_data_q <= ram_dout;
            rsp_err_q  <= par_err_c;
            if (par_err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            state <= S_RESP;
            ctl   <= decode(S_RESP, op_q);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
            ctl   <= decode(S_IDLE, 1'b0);
          end
        end
        default: begin
          state <= S_IDLE;
          ctl   <= decode(S_IDLE, 1'b0);
        end
      endcase
    end
  end

  assign bus.cmd_ready = ctl.cmd_ready;
  assign bus.rsp_valid = ctl.rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ram_blk_sel   = ctl.blk_sel;
  assign ram_addr_en   = ctl.addr_en;
  assign ram_wr_en     = ctl.wr_en;
  assign ram_rd_en     = ctl.rd_en;
  assign ram_dout_en   = ctl.dout_en;

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Bench for ram_cmd_ctrl: instance 0 (no address pipe, latency 2) and instance 1 (address pipe, latency 3),
// each with a behavioural RAM; expected data kept in a per-instance reference memory.
module tb_ram_cmd_ctrl;
  localparam int unsigned MW = 16;
  localparam int unsigned AW = 10;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         cmd_valid, cmd_op, rsp_ready, flip;
  logic [1:0][AW-1:0] cmd_addr;
  logic [1:0][MW-1:0] cmd_data;
  wire  [1:0]         cmd_ready, rsp_valid, rsp_err;
  wire  [1:0]         ram_wr_en, ram_rd_en, ram_blk_sel, ram_addr_en, ram_dout_en, ram_parity;
  wire  [1:0][MW-1:0] rsp_data, ram_din, ram_dout;
  wire  [1:0][AW-1:0] ram_addr;
  wire  [1:0][7:0]    err_cnt;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_mem [2][1024];
  int exp_cnt [2];

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int unsigned RL = (k == 0) ? 2 : 3;
    ram_cmd_ctrl_if #(.MEM_WIDTH(MW), .ADDR_SIZE(AW)) bus ();
    assign bus.cmd_valid = cmd_valid[k];
    assign bus.cmd_op    = cmd_op[k];
    assign bus.cmd_addr  = cmd_addr[k];
    assign bus.cmd_data  = cmd_data[k];
    assign bus.rsp_ready = rsp_ready[k];
    assign cmd_ready[k]  = bus.cmd_ready;
    assign rsp_valid[k]  = bus.rsp_valid;
    assign rsp_data[k]   = bus.rsp_data;
    assign rsp_err[k]    = bus.rsp_err;

    ram_cmd_ctrl #(.MEM_WIDTH(MW), .ADDR_SIZE(AW), .ADDR_PIPE(k), .RD_LATENCY(RL)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .err_cnt(err_cnt[k]),
      .ram_addr(ram_addr[k]), .ram_din(ram_din[k]), .ram_wr_en(ram_wr_en[k]),
      .ram_rd_en(ram_rd_en[k]), .ram_blk_sel(ram_blk_sel[k]), .ram_addr_en(ram_addr_en[k]),
      .ram_dout_en(ram_dout_en[k]), .ram_dout(ram_dout[k]), .ram_parity(ram_parity[k])
    );

    // RAM: read data appears RL edges after the issue edge; junk flows through otherwise
    logic [MW-1:0] mem  [1024];
    logic [MW-1:0] pipe [RL];
    always @(posedge clk) begin
      if (ram_blk_sel[k] && ram_wr_en[k]) mem[ram_addr[k]] <= ram_din[k];
      pipe[0] <= (ram_blk_sel[k] && ram_rd_en[k]) ? mem[ram_addr[k]] : MW'($urandom);
      for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout[k]   = pipe[RL-1];
    assign ram_parity[k] = (~^pipe[RL-1]) ^ flip[k];
  end

  function automatic int rl(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [6:0] pat(input int k);
    return {ram_blk_sel[k], ram_addr_en[k], ram_wr_en[k], ram_rd_en[k],
            ram_dout_en[k], cmd_ready[k], rsp_valid[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command from an IDLE negedge; walks each phase and checks pins; reads hold the response 'hold' cycles.
  task automatic do_cmd(input int k, input bit op, input logic [AW-1:0] a, input logic [MW-1:0] d,
                        input bit flp, input int hold);
    int n;
    bit e;
    logic [MW-1:0] hd;
    cmd_op[k] = op; cmd_addr[k] = a; cmd_data[k] = d; cmd_valid[k] = 1'b1; flip[k] = flp;
    n = 0;
    while (cmd_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    cmd_valid[k] = 1'b0; cmd_data[k] = MW'($urandom); cmd_addr[k] = AW'($urandom);
    chk("ram_addr", 32'(ram_addr[k]), 32'(a));
    chk("ram_din", 32'(ram_din[k]), 32'(d));
    if (k == 1) begin
      chk("setup_pat", 32'(pat(k)), 32'b0100000);
      @(negedge clk);
    end
    chk("issue_pat", 32'(pat(k)), op ? 32'b1101000 : 32'b1110000);
    @(negedge clk);
    if (!op) begin
      exp_mem[k][a] = d;
      chk("post_wr_pat", 32'(pat(k)), 32'b0000010);
      return;
    end
    for (int i = 0; i < rl(k); i++) begin
      chk("wait_pat", 32'(pat(k)), 32'b1000100);
      @(negedge clk);
    end
    e = flp && PAR;
    if (e && exp_cnt[k] < 255) exp_cnt[k]++;
    hd = exp_mem[k][a];
    for (int i = 0; i <= hold; i++) begin
      chk("resp_pat", 32'(pat(k)), 32'b0000001);
      chk("rsp_data", 32'(rsp_data[k]), 32'(hd));
      chk("rsp_err", 32'(rsp_err[k]), 32'(e));
      chk("err_cnt", 32'(err_cnt[k]), 32'(exp_cnt[k]));
      if (i == hold) rsp_ready[k] = 1'b1;
      @(negedge clk);
    end
    rsp_ready[k] = 1'b0; flip[k] = 1'b0;
    chk("post_rsp_pat", 32'(pat(k)), 32'b0000010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    rst = 1'b1;
    cmd_valid = '0; cmd_op = '0; rsp_ready = '0; flip = '0; cmd_addr = '0; cmd_data = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_pat", 32'(pat(k)), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data[k]), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("ready_after_rst", 32'(pat(k)), 32'b0000010);

    // Write then read back, both configurations; then a held response
    do_cmd(0, 1'b0, 10'h005, 16'hA5A5, 1'b0, 0);
    do_cmd(0, 1'b1, 10'h005, 16'h0000, 1'b0, 0);
    do_cmd(1, 1'b0, 10'h3FF, 16'h1234, 1'b0, 0);
    do_cmd(1, 1'b1, 10'h3FF, 16'h0000, 1'b0, 0);
    do_cmd(0, 1'b1, 10'h005, 16'h0000, 1'b0, 5);

    // Back-to-back writes with cmd_valid held high: one accept every two cycles
    cmd_valid[0] = 1'b1; cmd_op[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = AW'(i); d = MW'($urandom);
      cmd_addr[0] = a; cmd_data[0] = d;
      chk("b2b_ready", 32'(cmd_ready[0]), 32'd1);
      @(negedge clk);
      chk("b2b_issue", 32'(pat(0)), 32'b1110000);
      chk("b2b_addr", 32'(ram_addr[0]), 32'(a));
      exp_mem[0][a] = d;
      @(negedge clk);
    end
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 16; i++) do_cmd(0, 1'b1, AW'(i), 16'h0, 1'b0, int'($urandom_range(0, 2)));

    // Seed instance 1, then random traffic on both
    for (int i = 0; i < 16; i++) do_cmd(1, 1'b0, AW'(i), MW'($urandom), 1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      int k;
      k = i % 2;
      do_cmd(k, 1'($urandom), AW'($urandom_range(0, 15)), MW'($urandom), 1'b0,
             int'($urandom_range(0, 3)));
    end

    // Reset while instance 0 is in WAIT drops the read
    cmd_valid[0] = 1'b1; cmd_op[0] = 1'b1; cmd_addr[0] = 10'h005;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait", 32'(pat(0)), 32'b1000100);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("mid_rst_pat", 32'(pat(k)), 32'd0);
    #1 rst = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("after_rst_pat", 32'(pat(k)), 32'b0000010);
    @(negedge clk);
    chk("after_rst_idle", 32'(pat(0)), 32'b0000010);

    // Parity: one forced error, then saturation of the counter
    do_cmd(0, 1'b1, 10'h003, 16'h0, 1'b1, 0);
    do_cmd(0, 1'b1, 10'h004, 16'h0, 1'b0, 0);
    for (int i = 0; i < 299; i++) do_cmd(0, 1'b1, AW'($urandom_range(0, 15)), 16'h0, 1'b1, 0);
    chk("err_cnt_sat", 32'(err_cnt[0]), PAR ? 32'hFF : 32'h0);
    do_cmd(1, 1'b1, 10'h007, 16'h0, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
